planificador_bandas: RTL

// - Sequencer/arbiter in front of the band-painting FSM. Drives its 7-bit command input (bit0 start, bit1 static band, bits2..6 bands 1..5).
// - Issues one start command after reset.
// - Arbitrates five drum-pad band requests plus a static-band request.
// - Holds each granted command one-hot for a fixed time, then inserts an idle gap so the painter returns to its paint state.

---
 rtl/bandas_pkg.sv | 22 ++
 rtl/arbitro_rr5.sv | 36 +++
 rtl/planificador_bandas.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bandas_pkg.sv
// Shared types and constants for the band-painter command sequencer.
// Command bit layout: bit0 start, bit1 static band, bits 2..6 bands 1..5.
package bandas_pkg;

  typedef enum logic [1:0] {
    ARRANQUE = 2'd0,
    PAUSA    = 2'd1,
    ESPERA   = 2'd2,
    CONCEDE  = 2'd3
  } estado_e;

  localparam int         NUM_BANDAS    = 5;
  localparam logic [6:0] CMD_INICIO    = 7'b0000001;
  localparam logic [6:0] CMD_ESTATICA  = 7'b0000010;
  localparam int         CMD_BANDA_LSB = 2;

  // Round-robin pointer advance, wrapping band5 back to band1.
  function automatic logic [2:0] sig_ptr(input logic [2:0] idx);
    return (idx == 3'(NUM_BANDAS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/arbitro_rr5.sv
// Combinational 5-way round-robin picker: the first set request at or after
// ptr_i (modulo 5) wins. ptr_i is expected to stay in 0..4.
module arbitro_rr5
  import bandas_pkg::*;
(
  input  logic [4:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [4:0] gnt_onehot_o,
  output logic [2:0] idx_o,
  output logic       any_o
);

  logic [9:0] dbl;
  logic [9:0] rot_full;
  logic [4:0] rot;
  logic [2:0] off;
  logic [3:0] sum;

  // Doubling the vector turns the circular scan into a plain shift.
  assign dbl      = {req_i, req_i};
  assign rot_full = dbl >> ptr_i;
  assign rot      = rot_full[4:0];

  always_comb begin
    off = '0;
    for (int j = NUM_BANDAS - 1; j >= 0; j--) begin
      if (rot[j]) off = 3'(j);
    end
  end

  assign sum          = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o        = (sum >= 4'(NUM_BANDAS)) ? 3'(sum - 4'(NUM_BANDAS)) : sum[2:0];
  assign any_o        = |req_i;
  assign gnt_onehot_o = any_o ? (5'b00001 << idx_o) : 5'b00000;

endmodule

// File: rtl/planificador_bandas.sv
// Sequencer/arbiter in front of the band-painting FSM: one start command after
// reset, then round-robin band grants (static lowest) separated by idle gaps.
module planificador_bandas
  import bandas_pkg::*;
#(
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 2,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] req,
  input  logic       req_static,
  output logic [6:0] cmd,
  output logic [5:0] grant,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;

  if (HOLD_CYC < 1) begin : g_err_hold
    $error("planificador_bandas: HOLD_CYC must be >= 1");
  end
  if (GAP_CYC < 1) begin : g_err_gap
    $error("planificador_bandas: GAP_CYC must be >= 1");
  end
  if ((2 ** CW) <= MAX_CYC) begin : g_err_cw
    $error("planificador_bandas: CW too narrow for HOLD_CYC/GAP_CYC");
  end

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

  estado_e       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rr_q, rr_d;
  logic [6:0]    cmd_q, cmd_d;
  logic [5:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [4:0]    arb_gnt;
  logic [2:0]    arb_idx;
  logic          arb_any;

  arbitro_rr5 u_arbitro (
    .req_i        (req),
    .ptr_i        (rr_q),
    .gnt_onehot_o (arb_gnt),
    .idx_o        (arb_idx),
    .any_o        (arb_any)
  );

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe; ARRANQUE spends its first cycle with the reset
  // outputs and emits the start command in the second.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    cmd_d    = '0;
    grant_d  = '0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (estado_q)
      ARRANQUE: begin
        if (cmd_q == CMD_INICIO) begin
          estado_d = PAUSA;
          cnt_d    = GAP_LD;
        end else begin
          cmd_d = CMD_INICIO;
        end
      end
      PAUSA: begin
        if (cnt_q == '0) begin
          estado_d = ESPERA;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ESPERA: begin
        busy_d = 1'b0;
        if (enable && arb_any) begin
          estado_d = CONCEDE;
          cnt_d    = HOLD_LD;
          rr_d     = sig_ptr(arb_idx);
          cmd_d    = 7'(arb_gnt) << CMD_BANDA_LSB;
          grant_d  = {1'b0, arb_gnt};
          busy_d   = 1'b1;
          done_d   = (HOLD_LD == '0);
        end else if (enable && req_static) begin
          estado_d = CONCEDE;
          cnt_d    = HOLD_LD;
          cmd_d    = CMD_ESTATICA;
          grant_d  = 6'b100000;
          busy_d   = 1'b1;
          done_d   = (HOLD_LD == '0);
        end
      end
      CONCEDE: begin
        if (cnt_q == '0) begin
          estado_d = PAUSA;
          cnt_d    = GAP_LD;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          cmd_d   = cmd_q;
          grant_d = grant_q;
          done_d  = (cnt_q == CW'(1));
        end
      end
      default: estado_d = ARRANQUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ARRANQUE;
      cnt_q    <= '0;
      rr_q     <= '0;
      cmd_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      cmd_q    <= cmd_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cmd   = cmd_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

  a_cmd_onehot0 : assert property (@(posedge clk) $onehot0(cmd_q));

endmodule
